// File: rtl/muldiv_unit_if.sv
//------------------------------------------------------------------------------
// muldiv_unit_if : request/response bundle between the issuing FU and the
//                  shared HI/LO multiply/divide responder.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface muldiv_unit_if;
    logic        req;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic        ok;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output req, flush, op, srca, srcb,
        input  busy, ok, hi, lo
    );

    modport slave (
        input  req, flush, op, srca, srcb,
        output busy, ok, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
//------------------------------------------------------------------------------
// muldiv_unit : multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO with a
//               single-cycle ok pulse; flush aborts in-flight work.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_unit #(
    parameter int MUL_LAT = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    muldiv_unit_if.slave  mdu
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_CNT = 6'd33;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        neg_q;
    logic        rneg_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic        busy_q;
    logic        ok_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_mul_d;
    logic        is_div_d;
    logic        sgn_op_d;
    logic        a_neg_d;
    logic        b_neg_d;
    logic [31:0] mag_a_d;
    logic [31:0] mag_b_d;
    logic [63:0] prod_d;
    logic [63:0] prod_s_d;
    logic [32:0] shift_d;
    logic [32:0] diff_d;

    always_comb begin
        is_mul_d = (mdu.op == 3'd1) || (mdu.op == 3'd2);
        is_div_d = (mdu.op == 3'd3) || (mdu.op == 3'd4);
        sgn_op_d = (mdu.op == 3'd1) || (mdu.op == 3'd3);
        a_neg_d  = sgn_op_d & mdu.srca[31];
        b_neg_d  = sgn_op_d & mdu.srcb[31];
        mag_a_d  = a_neg_d ? (32'd0 - mdu.srca) : mdu.srca;
        mag_b_d  = b_neg_d ? (32'd0 - mdu.srcb) : mdu.srcb;
        // Product is taken on latched magnitudes; sign applied on the way out
        prod_d   = {32'd0, a_q} * {32'd0, b_q};
        prod_s_d = neg_q ? (64'd0 - prod_d) : prod_d;
        shift_d  = {rem_q, quo_q[31]};
        diff_d   = shift_d - {1'b0, b_q};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            busy_q  <= 1'b0;
            ok_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            ok_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mdu.req && !mdu.flush && (is_mul_d || is_div_d)) begin
                        a_q    <= mag_a_d;
                        b_q    <= mag_b_d;
                        neg_q  <= a_neg_d ^ b_neg_d;
                        rneg_q <= a_neg_d;
                        rem_q  <= 32'd0;
                        quo_q  <= mag_a_d;
                        busy_q <= 1'b1;
                        if (is_mul_d) begin
                            state_q <= ST_MUL;
                            cnt_q   <= MUL_CNT;
                        end else begin
                            state_q <= ST_DIV;
                            cnt_q   <= DIV_CNT;
                        end
                    end
                end
                ST_MUL: begin
                    if (mdu.flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= 6'd0;
                    end else if (cnt_q == 6'd0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        ok_q    <= 1'b1;
                        hi_q    <= prod_s_d[63:32];
                        lo_q    <= prod_s_d[31:0];
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end
                ST_DIV: begin
                    if (mdu.flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= 6'd0;
                    end else if (cnt_q == 6'd0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        ok_q    <= 1'b1;
                        hi_q    <= rem_q;
                        lo_q    <= quo_q;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                        // Counts 33..2 run the 32 restoring steps; count 1 fixes signs
                        if (cnt_q == 6'd1) begin
                            quo_q <= neg_q  ? (32'd0 - quo_q) : quo_q;
                            rem_q <= rneg_q ? (32'd0 - rem_q) : rem_q;
                        end else if (!diff_d[32]) begin
                            rem_q <= diff_d[31:0];
                            quo_q <= {quo_q[30:0], 1'b1};
                        end else begin
                            rem_q <= shift_d[31:0];
                            quo_q <= {quo_q[30:0], 1'b0};
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mdu.busy = busy_q;
    assign mdu.ok   = ok_q;
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
//------------------------------------------------------------------------------
// tb_muldiv_unit : directed plus randomized checks of muldiv_unit against an
//                  arithmetic reference model.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_unit;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 34;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [63:0] last_exp;

    muldiv_unit_if mdu ();

    muldiv_unit #(.MUL_LAT(MUL_LAT)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .mdu    (mdu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    // Reference: {hi, lo} straight from the arithmetic definition of each op
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [31:0] q;
        logic [31:0] r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: res = 64'(sa * sb);
            3'd2: res = {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0) begin
                    q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
                    r = a;
                end else begin
                    q = 32'(sa / sb);
                    r = 32'(sa % sb);
                end
                res = {r, q};
            end
            3'd4: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else            res = {a % b, a / b};
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int          lat;
        bit          seen;
        exp  = model(op, a, b);
        lat  = (op <= 3'd2) ? MUL_LAT : DIV_LAT;
        seen = 1'b0;
        @(negedge clk);
        mdu.req  = 1'b1;
        mdu.op   = op;
        mdu.srca = a;
        mdu.srcb = b;
        @(posedge clk);
        #1;
        mdu.srca = $urandom;
        mdu.srcb = $urandom;
        for (int k = 1; k <= lat + 5 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (mdu.ok) begin
                seen = 1'b1;
                chk("latency", 64'(k), 64'(lat));
                chk("hi", 64'(mdu.hi), 64'(exp[63:32]));
                chk("lo", 64'(mdu.lo), 64'(exp[31:0]));
                chk("busy_in_done", 64'(mdu.busy), 64'd0);
            end else if (k < lat) begin
                chk("busy_during_op", 64'(mdu.busy), 64'd1);
            end
        end
        chk("ok_seen", 64'(seen), 64'd1);
        mdu.req = 1'b0;
        last_exp = exp;
        @(posedge clk);
        #1;
        chk("ok_single_cycle", 64'(mdu.ok), 64'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;
        checks   = 0;
        errors   = 0;
        last_exp = 64'd0;
        rst_n    = 1'b0;
        mdu.req   = 1'b0;
        mdu.flush = 1'b0;
        mdu.op    = 3'd0;
        mdu.srca  = 32'd0;
        mdu.srcb  = 32'd0;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(mdu.busy), 64'd0);
        chk("rst_ok", 64'(mdu.ok), 64'd0);
        chk("rst_hi", 64'(mdu.hi), 64'd0);
        chk("rst_lo", 64'(mdu.lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("idle_ok", 64'(mdu.ok), 64'd0);
            chk("idle_busy", 64'(mdu.busy), 64'd0);
        end
        chk("idle_hi", 64'(mdu.hi), 64'd0);
        chk("idle_lo", 64'(mdu.lo), 64'd0);

        // Directed arithmetic cases
        do_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        do_op(3'd2, 32'hFFFF_FFFE, 32'd3);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'd4, 32'h1234_5678, 32'd0);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd0);

        // Flush mid-DIVU: no ok, results untouched
        @(negedge clk);
        mdu.req  = 1'b1;
        mdu.op   = 3'd4;
        mdu.srca = 32'd100;
        mdu.srcb = 32'd7;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        mdu.flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_busy", 64'(mdu.busy), 64'd0);
        chk("flush_ok", 64'(mdu.ok), 64'd0);
        mdu.flush = 1'b0;
        mdu.req   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            chk("flush_no_ok", 64'(mdu.ok), 64'd0);
        end
        chk("flush_hi_kept", 64'(mdu.hi), 64'(last_exp[63:32]));
        chk("flush_lo_kept", 64'(mdu.lo), 64'(last_exp[31:0]));
        do_op(3'd2, 32'd5, 32'd6);

        // Flush in IDLE blocks acceptance; ops 5..7 are never accepted
        @(negedge clk);
        mdu.req   = 1'b1;
        mdu.op    = 3'd1;
        mdu.flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("idle_flush_busy", 64'(mdu.busy), 64'd0);
        end
        mdu.flush = 1'b0;
        mdu.op    = 3'd6;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("op_none_busy", 64'(mdu.busy), 64'd0);
            chk("op_none_ok", 64'(mdu.ok), 64'd0);
        end
        mdu.req = 1'b0;

        // Randomized ops with operand corner mixing
        for (int n = 0; n < 24; n++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            sel = int'($urandom_range(0, 7));
            case (sel)
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                3: begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
                default: rb = $urandom;
            endcase
            do_op(rop, ra, rb);
        end

        // Asynchronous reset in the middle of a DIV
        @(negedge clk);
        mdu.req  = 1'b1;
        mdu.op   = 3'd3;
        mdu.srca = 32'd1000;
        mdu.srcb = 32'd3;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(mdu.busy), 64'd0);
        chk("arst_ok", 64'(mdu.ok), 64'd0);
        chk("arst_hi", 64'(mdu.hi), 64'd0);
        chk("arst_lo", 64'(mdu.lo), 64'd0);
        mdu.req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            chk("arst_no_ok", 64'(mdu.ok), 64'd0);
            chk("arst_no_busy", 64'(mdu.busy), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Shared multi-cycle multiply/divide responder for the dual-issue execute stage. It accepts at most one HI/LO-producing request at a time from whichever functional unit issued it (lane 1 has priority, muxed upstream). It computes the 64-bit result and returns `hi`/`lo` with a one-cycle `ok` completion pulse. `flush` aborts any in-flight operation.

## Interface
- `MUL_LAT`, 3: cycles from request acceptance to `ok` for MULT/MULTU; legal range 1..8.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort of the current operation.
- `req`  in  1  request valid; held high by the requester until it observes `ok`.
- `op`  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU; 5–7 are treated as NONE.
- `srca`  in  32  rs operand (multiplicand / dividend).
- `srcb`  in  32  rt operand (multiplier / divisor).
- `busy`  out  1  high while in MUL or DIV state.
- `ok`  out  1  registered single-cycle completion pulse.
- `hi`  out  32  registered HI result; holds its value between completions.
- `lo`  out  32  registered LO result; holds its value between completions.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE
  - Accept when `req` && `op` ∈ {1..4} && !`flush`.
  - On accept, latch operand magnitudes, result signs, and op kind, and load the cycle counter.
  - Go to MUL for ops 1/2 and DIV for ops 3/4.
  - Otherwise stay in IDLE.
- MUL
  - Product computed over `MUL_LAT` cycles: a retimable register chain or a single multiply followed by delay stages.
  - MULT is signed 32×32→64; MULTU is unsigned.
  - When the counter expires, go to DONE.
  - `hi` = product[63:32], `lo` = product[31:0].
- DIV
  - Radix-2 restoring divide on magnitudes, 32 iterations, one quotient bit per cycle.
  - Then one sign-fixup cycle, then DONE.
  - DIV signs: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - `lo` = quotient, `hi` = remainder.
- Divide-by-zero (srcb = 0): the natural restoring result is required, not an exception.
  - DIVU: `lo` = 0xFFFFFFFF, `hi` = srca.
  - DIV: quotient magnitude 0xFFFFFFFF, then signed as above; remainder = srca.
- Overflow case 0x80000000 / 0xFFFFFFFF (DIV): `lo` = 0x80000000, `hi` = 0.
- DONE
  - `ok` = 1 and `hi`/`lo` updated in this cycle.
  - Next cycle: return to IDLE. A new request may be accepted on the cycle after DONE.
  - The requester must drop `req`, or present the next op, on the cycle following `ok`.
- `flush` in MUL or DIV: next state IDLE, partial results discarded, no `ok` for the aborted op, `hi`/`lo` unchanged.
- `flush` while in DONE: `ok` still pulses (already committed); the FU discards it.
- `flush` in IDLE: no accept that cycle.
- Operands and `op` are sampled only at acceptance; later changes are ignored.

## Timing
- Reset values: state IDLE, `busy` 0, `ok` 0, `hi` 0, `lo` 0, counter 0.
- Acceptance at edge t0 (IDLE, `req` high).
  - MUL: `ok` high during cycle t0+`MUL_LAT`.
  - DIV: `ok` high during cycle t0+34 (32 iterations + fixup + DONE).
- `busy` is high from t0+1 until the DONE cycle; it is low in DONE and in IDLE.
- `ok` is never high on two consecutive cycles.
- Back-to-back issue: minimum spacing between accepts is latency+1 cycles.
- Reset asserted mid-operation: immediate return to all reset values, independent of `clk`.
- All arithmetic is modulo 2^32 per half; there are no sticky status bits.

## Test plan
- Reset release, idle: `reset` low then high, `req`=0 for 10 cycles → `hi`=`lo`=0, `ok`/`busy` never high.
- MULT signed: srca=0xFFFFFFFE (−2), srcb=3, `MUL_LAT`=3 → `ok` at t0+3, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. Then MULTU with the same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV signed: srca=−7 (0xFFFFFFF9), srcb=2 → `ok` exactly at t0+34, `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1). Boundary case 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU by zero: srca=0x12345678, srcb=0 → `lo`=0xFFFFFFFF, `hi`=0x12345678.
- Flush abort: start DIVU 100/7, assert `flush` at t0+10 → `busy` low next cycle, no `ok`, `hi`/`lo` keep their prior values. A new MULTU 5×6 accepted afterwards → `lo`=30, `hi`=0 at its normal latency.
- Async reset mid-DIV: pull `reset` low at t0+5 between clock edges → `busy`, `ok`, `hi`, `lo` go to 0 immediately, and no `ok` appears after release.
